// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between four requesters and the mux arbiter.
// Requesters drive req; the arbiter returns grant, select and busy.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  busy
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter driving the select of a shared 4:1 mux.
// Bounded hold time keeps a persistent requester from starving others.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  mux4_rr_arbiter_if.slave  bus
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] gnt_q;
  logic [1:0] sel_q;
  logic       busy_q;
  logic [1:0] ptr;
  logic [7:0] cnt;

  logic [3:0] others;
  logic [1:0] win;
  logic       win_vld;
  logic       owner_req;
  logic       at_max;

  logic       do_grant;
  logic       do_idle;
  logic       do_wrap;
  logic       do_inc;

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

  // Mux wiring takes s[0] as the high-order index bit.
  function automatic logic [1:0] sel_of(input logic [1:0] k);
    return {k[0], k[1]};
  endfunction

  // Round-robin search over pending non-owner requests from ptr.
  always_comb begin
    logic [1:0] idx;
    others  = bus.req & ~gnt_q;
    win     = ptr;
    win_vld = 1'b0;
    idx     = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (others[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign owner_req = |(bus.req & gnt_q);
  assign at_max    = (cnt == HOLD_MAX);

  // Decode the action taken at the next edge.
  always_comb begin
    do_grant = 1'b0;
    do_idle  = 1'b0;
    do_wrap  = 1'b0;
    do_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        do_grant = win_vld;
      end
      BUSY: begin
        do_grant = win_vld &
                   (~owner_req | at_max);
        do_idle  = ~owner_req & ~win_vld;
        do_wrap  = owner_req & at_max &
                   ~win_vld;
        do_inc   = owner_req & ~at_max;
      end
      default: ;
    endcase
  end

  // Owner FSM with registered grant, select and busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt_q  <= 4'b0000;
      sel_q  <= 2'b00;
      busy_q <= 1'b0;
      ptr    <= 2'd0;
      cnt    <= 8'd0;
    end else begin
      unique case (1'b1)
        do_grant: begin
          state  <= BUSY;
          gnt_q  <= 4'b0001 << win;
          sel_q  <= sel_of(win);
          busy_q <= 1'b1;
          ptr    <= win + 2'd1;
          cnt    <= 8'd1;
        end
        do_idle: begin
          state  <= IDLE;
          gnt_q  <= 4'b0000;
          busy_q <= 1'b0;
        end
        do_wrap: begin
          cnt <= 8'd1;
        end
        do_inc: begin
          cnt <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter.
// Vector table, directed corner sequences and a random model comparison.
module tb_mux4_rr_arbiter;

  localparam int MAXH = 8;

  logic clk;
  logic rst;
  logic [3:0] mux_i;
  logic       mux_y;

  int n_checks;
  int n_errors;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Team 4:1 mux: s[0] is the high-order select bit.
  assign mux_y = mux_i[{bus.sel[0], bus.sel[1]}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t vecs [11];

  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_sel;
  int sel_tab [4] = '{0, 2, 1, 3};

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_sel   = 0;
  endtask

  task automatic m_grant(input int w);
    m_owner = w;
    m_ptr   = (w + 1) % 4;
    m_cnt   = 1;
    m_sel   = sel_tab[w];
  endtask

  // Reference: one arbitration decision per clock edge.
  task automatic m_step(input logic [3:0] r);
    logic [3:0] oth;
    int w;
    int k;
    oth = r;
    if (m_owner >= 0) oth[m_owner] = 1'b0;
    w = -1;
    for (int o = 0; o < 4; o++) begin
      k = (m_ptr + o) % 4;
      if (oth[k] && w < 0) w = k;
    end
    if (m_owner < 0) begin
      if (w >= 0) m_grant(w);
    end else if (!r[m_owner]) begin
      if (w >= 0) m_grant(w);
      else m_owner = -1;
    end else if (m_cnt == MAXH) begin
      if (w >= 0) m_grant(w);
      else m_cnt = 1;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.req = 4'b0000;
    mux_i = 4'b1010;
    m_reset();

    vecs[0]  = '{4'b0000, 4'b0000, 2'b00, 1'b0};
    vecs[1]  = '{4'b0100, 4'b0100, 2'b01, 1'b1};
    vecs[2]  = '{4'b0100, 4'b0100, 2'b01, 1'b1};
    vecs[3]  = '{4'b0000, 4'b0000, 2'b01, 1'b0};
    vecs[4]  = '{4'b1010, 4'b1000, 2'b11, 1'b1};
    vecs[5]  = '{4'b0011, 4'b0001, 2'b00, 1'b1};
    vecs[6]  = '{4'b0010, 4'b0010, 2'b10, 1'b1};
    vecs[7]  = '{4'b0110, 4'b0010, 2'b10, 1'b1};
    vecs[8]  = '{4'b0100, 4'b0100, 2'b01, 1'b1};
    vecs[9]  = '{4'b0000, 4'b0000, 2'b01, 1'b0};
    vecs[10] = '{4'b1111, 4'b1000, 2'b11, 1'b1};

    // Reset held with random requests.
    for (int c = 0; c < 6; c++) begin
      bus.req = 4'($urandom);
      #3;
      chk("rst_gnt", 8'(bus.gnt), 8'h0);
      chk("rst_sel", 8'(bus.sel), 8'h0);
      chk("rst_busy", 8'(bus.busy), 8'h0);
      tick();
    end

    // Vector table.
    do_reset();
    foreach (vecs[i]) begin
      bus.req = vecs[i].req;
      tick();
      chk($sformatf("vec%0d_gnt", i), 8'(bus.gnt), 8'(vecs[i].gnt));
      chk($sformatf("vec%0d_sel", i), 8'(bus.sel), 8'(vecs[i].sel));
      chk($sformatf("vec%0d_busy", i), 8'(bus.busy), 8'(vecs[i].busy));
    end

    // Asynchronous reset mid-grant clears without an edge.
    #1;
    rst = 1'b1;
    #1;
    chk("async_gnt", 8'(bus.gnt), 8'h0);
    chk("async_busy", 8'(bus.busy), 8'h0);
    chk("async_sel", 8'(bus.sel), 8'h0);
    rst = 1'b0;
    bus.req = 4'b0000;
    m_reset();

    // All requesting: 8-cycle windows in rotation, no gaps.
    do_reset();
    bus.req = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      tick();
      chk("rot_gnt", 8'(bus.gnt), 8'(4'b0001 << ((c / MAXH) % 4)));
      chk("rot_sel", 8'(bus.sel), 8'(sel_tab[(c / MAXH) % 4]));
    end

    // Lone requester keeps the grant past MAX_HOLD.
    do_reset();
    bus.req = 4'b0010;
    for (int c = 0; c < 30; c++) begin
      tick();
      chk("lone_gnt", 8'(bus.gnt), 8'h02);
    end

    // Arbiter plus mux, then reset mid-window.
    do_reset();
    mux_i = 4'b1010;
    bus.req = 4'b1111;
    for (int c = 0; c < 32; c++) begin
      tick();
      chk("mux_y", 8'(mux_y), 8'(mux_i[(c / MAXH) % 4]));
    end
    repeat (3) tick();
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_gnt", 8'(bus.gnt), 8'h0);
    rst = 1'b0;
    m_reset();
    tick();
    chk("post_rst_gnt", 8'(bus.gnt), 8'h01);
    chk("post_rst_sel", 8'(bus.sel), 8'h00);

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 7) == 0) bus.req[k] = ~bus.req[k];
      end
      m_step(bus.req);
      tick();
      chk("rnd_gnt", 8'(bus.gnt),
          (m_owner < 0) ? 8'h0 : 8'(4'b0001 << m_owner));
      chk("rnd_sel", 8'(bus.sel), 8'(m_sel));
      chk("rnd_busy", 8'(bus.busy), 8'(m_owner >= 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
